// File: rtl/exp_pulse_gen.sv
// exp_pulse_gen
// Synthesizes ADC-like detector pulses: a linear rise of RISE_LEN samples up to
// the latched amplitude, then an exponential tail (acc -= acc >> DECAY_SHIFT per
// sample) followed by HOLDOFF_LEN dead samples. Every sample is offset by a
// programmable baseline and saturated to the unsigned output range.
// Pulses start from the single-shot trig input or from an auto-repeat timer.
//
// Optional build macro:
//   PULSE_GEN_PILEUP_EN - when defined, triggers are also accepted during the
//   tail and holdoff. The new amplitude is added on top of the running tail
//   with no rise ramp, so the pulses superpose. When undefined, triggers are
//   accepted only in IDLE and no pile-up logic exists.
//
// The accumulator holds the pulse height in fixed point with
// FRAC = SIZE_ACC - SIZE_ADC_DATA fractional bits.
// Constraints: DECAY_SHIFT < FRAC, RISE_LEN a power of two >= 1,
// HOLDOFF_LEN >= 1.
module exp_pulse_gen #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int SIZE_ACC      = 24,
    parameter int DECAY_SHIFT   = 5,
    parameter int RISE_LEN      = 4,
    parameter int HOLDOFF_LEN   = 16,
    parameter int SIZE_PERIOD   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trig,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    input  logic [SIZE_PERIOD-1:0]   period,
    output logic                     ready,
    output logic                     busy,
    output logic                     pulse_start,
    output logic [SIZE_PERIOD-1:0]   pulse_count,
    output logic [SIZE_ADC_DATA-1:0] output_data
);

    localparam int FRAC       = SIZE_ACC - SIZE_ADC_DATA;
    localparam int RISE_SHIFT = $clog2(RISE_LEN);
    // The rise counter holds 1..RISE_LEN-1; the hold counter holds 0..HOLDOFF_LEN-1.
    localparam int RISE_CW    = $clog2(RISE_LEN + 1);
    localparam int HOLD_CW    = $clog2(HOLDOFF_LEN + 1);

    localparam logic [RISE_CW-1:0] RISE_FIRST = RISE_CW'(1);
    localparam logic [RISE_CW-1:0] RISE_LAST  = RISE_CW'(RISE_LEN - 1);
    localparam logic [HOLD_CW-1:0] HOLD_LAST  = HOLD_CW'(HOLDOFF_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RISE    = 2'd1,
        ST_DECAY   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic [SIZE_ACC-1:0]      acc_q, acc_d;
    logic [SIZE_ADC_DATA-1:0] amp_q, amp_d;
    logic [RISE_CW-1:0]       rise_cnt_q, rise_cnt_d;
    logic [HOLD_CW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [SIZE_PERIOD-1:0]   timer_q, timer_d;
    logic                     pulse_start_q, pulse_start_d;
    logic [SIZE_PERIOD-1:0]   pulse_count_q, pulse_count_d;
    logic [SIZE_ADC_DATA-1:0] out_q, out_d;
    logic                     busy_q, busy_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    // Amplitude aligned to the accumulator's integer part: the input value
    // is used on the accept edge, the latched copy for the rest of the rise.
    logic [SIZE_ACC-1:0] amp_full_in;
    logic [SIZE_ACC-1:0] amp_full_q;
    logic [SIZE_ACC-1:0] step_in;
    logic [SIZE_ACC-1:0] step_q;
    logic [SIZE_ACC-1:0] decay_next;
    logic                tail_done;

    assign amp_full_in = {amplitude, {FRAC{1'b0}}};
    assign amp_full_q  = {amp_q, {FRAC{1'b0}}};
    assign step_in     = amp_full_in >> RISE_SHIFT;
    assign step_q      = amp_full_q >> RISE_SHIFT;
    assign decay_next  = acc_q - (acc_q >> DECAY_SHIFT);
    // The tail is over once less than one output LSB remains.
    assign tail_done   = (acc_q[SIZE_ACC-1:FRAC] == '0);

    // ------------------------------------------------------------------
    // Auto-repeat timer
    // ------------------------------------------------------------------
    logic                   timer_run;
    logic [SIZE_PERIOD-1:0] period_last;
    logic                   auto_trig;

    assign timer_run   = enable && (period != '0);
    assign period_last = period - SIZE_PERIOD'(1);
    assign auto_trig   = timer_run && (timer_q == period_last);

    // Timer next value: held at 0 when off; a period shrunk below the
    // current count wraps immediately without firing.
    always_comb begin
        timer_d = '0;
        if (timer_run && (timer_q < period_last)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Trigger acceptance
    // ------------------------------------------------------------------
    logic accept;

`ifdef PULSE_GEN_PILEUP_EN
    // A new pulse may land on top of a tail or during holdoff, never mid-rise.
    logic [SIZE_ACC:0]   pile_sum;
    logic [SIZE_ACC-1:0] pile_sat;

    assign ready    = enable && (state_q != ST_RISE);
    assign pile_sum = {1'b0, acc_q} + {1'b0, amp_full_in};
    assign pile_sat = pile_sum[SIZE_ACC] ? {SIZE_ACC{1'b1}} : pile_sum[SIZE_ACC-1:0];
`else
    assign ready = enable && (state_q == ST_IDLE);
`endif

    assign accept = ready && (trig || auto_trig);

    // ------------------------------------------------------------------
    // Pulse FSM: next state, accumulator and counters
    // ------------------------------------------------------------------
    // Next-state and accumulator update for the rise/decay/holdoff sequence.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        amp_d         = amp_q;
        rise_cnt_d    = rise_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        pulse_start_d = 1'b0;
        pulse_count_d = pulse_count_q;

        if (accept) begin
            amp_d         = amplitude;
            pulse_start_d = 1'b1;
            pulse_count_d = pulse_count_q + 1'b1;
            rise_cnt_d    = RISE_FIRST;
            hold_cnt_d    = '0;
`ifdef PULSE_GEN_PILEUP_EN
            if (state_q != ST_IDLE) begin
                // Superpose on the running tail; no ramp.
                acc_d   = pile_sat;
                state_d = ST_DECAY;
            end else if (RISE_LEN == 1) begin
                acc_d   = amp_full_in;
                state_d = ST_DECAY;
            end else begin
                acc_d   = step_in;
                state_d = ST_RISE;
            end
`else
            if (RISE_LEN == 1) begin
                // No ramp at all: jump straight to the peak.
                acc_d   = amp_full_in;
                state_d = ST_DECAY;
            end else begin
                // The accept edge produces the first rise sample.
                acc_d   = step_in;
                state_d = ST_RISE;
            end
`endif
        end else begin
            case (state_q)
                ST_RISE: begin
                    if (rise_cnt_q == RISE_LAST) begin
                        // Last rise sample lands exactly on the peak,
                        // independent of step truncation.
                        acc_d   = amp_full_q;
                        state_d = ST_DECAY;
                    end else begin
                        acc_d      = acc_q + step_q;
                        rise_cnt_d = rise_cnt_q + 1'b1;
                    end
                end
                ST_DECAY: begin
                    if (tail_done) begin
                        acc_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = ST_HOLDOFF;
                    end else begin
                        acc_d = decay_next;
                    end
                end
                ST_HOLDOFF: begin
                    acc_d = '0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    acc_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output sample and status
    // ------------------------------------------------------------------
    logic [SIZE_ADC_DATA:0] out_sum;

    assign out_sum = {1'b0, baseline} + {1'b0, acc_q[SIZE_ACC-1:FRAC]};

    // Baseline plus integer part of acc, clamped at full scale instead of wrapping.
    always_comb begin
        out_d  = out_sum[SIZE_ADC_DATA] ? {SIZE_ADC_DATA{1'b1}} : out_sum[SIZE_ADC_DATA-1:0];
        busy_d = (state_d != ST_IDLE);
    end

    // All state registers; reset aborts any pulse in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            amp_q         <= '0;
            rise_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            timer_q       <= '0;
            pulse_start_q <= 1'b0;
            pulse_count_q <= '0;
            out_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            amp_q         <= amp_d;
            rise_cnt_q    <= rise_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            timer_q       <= timer_d;
            pulse_start_q <= pulse_start_d;
            pulse_count_q <= pulse_count_d;
            out_q         <= out_d;
            busy_q        <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign pulse_start = pulse_start_q;
    assign pulse_count = pulse_count_q;
    assign output_data = out_q;

endmodule

// File: doc/exp_pulse_gen.md
Name: exp_pulse_gen

Overview:
- Synthesizes ADC-like detector pulses with a linear rise and an exponential tail (decay factor 1 - 2^-DECAY_SHIFT per sample) on a programmable baseline.
- Acts as the source end of the shaping-filter chain: it drives stimulus into the trapezoidal/DKL filter input in bench and self-test builds.
- Pulses start from a single-shot trigger or from an internal auto-repeat timer.

Parameters:
SIZE_ADC_DATA, 12, output sample width
SIZE_ACC, 24, accumulator width; FRAC = SIZE_ACC - SIZE_ADC_DATA fractional bits
DECAY_SHIFT, 5, tail decay shift; must be < FRAC
RISE_LEN, 4, rise length in samples; power of 2, >= 1
HOLDOFF_LEN, 16, dead samples after a pulse
SIZE_PERIOD, 16, width of period and pulse_count

Ports:
clk  in  1  sample clock
reset  in  1  asynchronous, active-low reset
enable  in  1  permits new pulses and runs the auto-repeat timer
trig  in  1  single-shot pulse request, sampled each clock
amplitude  in  SIZE_ADC_DATA  pulse height in LSB, latched on accept
baseline  in  SIZE_ADC_DATA  DC offset added to the pulse
period  in  SIZE_PERIOD  auto-repeat period in clocks; 0 = off
ready  out  1  combinational: a trigger would be accepted this cycle
busy  out  1  registered: state != IDLE
pulse_start  out  1  one-cycle strobe on each accepted trigger
pulse_count  out  SIZE_PERIOD  accepted-pulse counter, wraps
output_data  out  SIZE_ADC_DATA  registered sample

Behaviour:
- Reset (async, reset==0): state IDLE, acc 0, all counters 0, output_data 0, busy 0, pulse_start 0, pulse_count 0. A reset in any state aborts the pulse immediately.
- Effective trigger: trig OR auto_trig. Accept condition: ready = enable && state==IDLE.
- On accept:
  - amplitude is latched.
  - step = (amplitude << FRAC) >> log2(RISE_LEN).
  - acc <= step; state <= RISE, or DECAY with acc <= amplitude<<FRAC if RISE_LEN==1.
  - pulse_start <= 1 for one cycle; pulse_count increments.
- RISE: acc += step each clock. The RISE_LEN-th sample (accept edge counts as the first) forces acc = amplitude<<FRAC, then state goes to DECAY.
- DECAY: acc <= acc - (acc >> DECAY_SHIFT) each clock. When (acc >> FRAC) == 0, acc <= 0 and state goes to HOLDOFF.
- HOLDOFF: HOLDOFF_LEN clocks with acc 0, then IDLE.
- A trigger arriving while not ready is ignored: no strobe, no count change.
- amplitude==0: the pulse is accepted and counted; it passes through RISE and DECAY exits on the first DECAY cycle.
- Output: output_data <= min(baseline + (acc >> FRAC), 2^SIZE_ADC_DATA-1), saturating unsigned. Computed every clock in every state, so it lags acc by one cycle.
- Auto-repeat timer:
  - Runs while enable==1 and period!=0; otherwise it is held at 0.
  - Counts 0..period-1; auto_trig fires when count==period-1, then wraps to 0.
  - An auto_trig that lands while not ready is dropped; the timer keeps running.
- enable deassert mid-pulse: the current pulse completes normally; no new accept.
- period changes take effect at the next wrap, or immediately if the new period-1 < count, in which case the timer wraps to 0.

Optional Feature:
PULSE_GEN_PILEUP_EN
- Defined:
  - ready = enable && state!=RISE.
  - A trigger accepted in DECAY or HOLDOFF does acc <= sat(acc + (amplitude<<FRAC)) (saturate at all-ones SIZE_ACC), state <= DECAY with no rise ramp, pulse_start strobes and pulse_count increments.
  - Pile-up superposes pulses for filter pile-up testing.
- Undefined: triggers are accepted in IDLE only, as above. No pile-up logic is synthesized.

Test Plan:
1. Reset release, baseline=100, no trig -> output_data 0 during reset, 100 from first clock after release; busy 0, ready==enable.
2. baseline=100, amplitude=1000, one trig -> pulse_start 1 cycle, pulse_count=1. Following outputs: 350, 600, 850, 1100, then 1068 (acc 3968000). Thereafter monotonically non-increasing to 100; busy drops HOLDOFF_LEN clocks after the tail ends.
3. baseline=3500, amplitude=1000 -> peak output_data clamps at 4095, no wrap; tail resumes below 4095 once 3500+height<4095.
4. amplitude=1000, trig again 10 and 100 clocks after the first -> both ignored, pulse_count stays 1, waveform identical to scenario 2.
5. period=400, amplitude=500, enable=1 for 1200 clocks -> pulse_start exactly every 400 clocks, pulse_count=3; period=150 -> every other auto_trig dropped (pulse length exceeds 150).
6. Assert reset mid-DECAY -> output_data, busy, pulse_count go 0 asynchronously; after release a new trig produces the scenario 2 waveform. With PULSE_GEN_PILEUP_EN, a second trig 20 clocks into DECAY raises the height by 1000 with no ramp, and pulse_count=2.
